// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline control blocks.
// Holds the hazard FSM state type and register-index constants.
package core_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the hazard controller's performance statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mul/div freeze and taken-branch squash.
// Control outputs are combinational from the registered state and the current inputs.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int MC_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             ID_EX_mc,
    input  logic             mc_done,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic             mc_start,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mc_stall_cnt,
    output logic             dbg_state_o
);

    localparam int TMR_W = $clog2(MC_MAX + 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tout_q, tout_d;
    logic             load_use;
    logic             lu_inc;
    logic             mc_inc;

    assign load_use = ID_EX_MemRead && (ID_EX_rd != ZERO_REG) &&
                      (((ID_EX_rd == IF_ID_rs1) && IF_ID_use_rs1) ||
                       ((ID_EX_rd == IF_ID_rs2) && IF_ID_use_rs2));

    // Reset forces default controls so an interrupted mul/div never re-issues mc_start.
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        tout_d        = tout_q;
        lu_inc        = 1'b0;
        mc_inc        = 1'b0;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        mc_start      = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_EX_mc) begin
                        mc_start      = 1'b1;
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        state_d       = MC_BUSY;
                        tmr_d         = '0;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        lu_inc      = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_done) begin
                        state_d = RUN;
                    end else begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        mc_inc        = 1'b1;
                        if (tmr_q != TMR_W'(MC_MAX)) begin
                            tmr_d = tmr_q + 1'b1;
                        end
                        if (tmr_q == TMR_W'(MC_MAX - 1)) begin
                            tout_d = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tmr_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            tout_q  <= tout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lu_inc),
        .cnt (lu_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mc_inc),
        .cnt (mc_stall_cnt)
    );

    assign mc_timeout  = tout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short mul/div timeout.
// Control vector order: PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, mc_start.
module tb_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int MC_MAX = 4;

    localparam logic [6:0] C_DEF  = 7'b111_0000;
    localparam logic [6:0] C_LU   = 7'b001_0100;
    localparam logic [6:0] C_BR   = 7'b111_1100;
    localparam logic [6:0] C_MCS  = 7'b000_0011;
    localparam logic [6:0] C_BUSY = 7'b000_0010;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mem_read = 1'b0;
    logic [4:0]       ex_rd = '0;
    logic [4:0]       rs1 = '0;
    logic [4:0]       rs2 = '0;
    logic             use1 = 1'b0;
    logic             use2 = 1'b0;
    logic             ex_mc = 1'b0;
    logic             done = 1'b0;
    logic             br = 1'b0;
    logic             pc_wr, ifid_wr, idex_wr, ifid_fl, idex_fl, exmem_bub, mc_st, tout;
    logic [CNT_W-1:0] lu_cnt, mc_cnt;
    logic             st;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MC_MAX(MC_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_EX_MemRead (mem_read),
        .ID_EX_rd      (ex_rd),
        .IF_ID_rs1     (rs1),
        .IF_ID_rs2     (rs2),
        .IF_ID_use_rs1 (use1),
        .IF_ID_use_rs2 (use2),
        .ID_EX_mc      (ex_mc),
        .mc_done       (done),
        .branch_taken  (br),
        .PCWrite       (pc_wr),
        .IF_ID_Write   (ifid_wr),
        .ID_EX_Write   (idex_wr),
        .IF_ID_Flush   (ifid_fl),
        .ID_EX_Flush   (idex_fl),
        .EX_MEM_Bubble (exmem_bub),
        .mc_start      (mc_st),
        .mc_timeout    (tout),
        .lu_stall_cnt  (lu_cnt),
        .mc_stall_cnt  (mc_cnt),
        .dbg_state_o   (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then compare controls mid-cycle.
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u1, input logic u2,
                        input logic mc, input logic dn, input logic b,
                        input logic [6:0] exp, input string tag);
        logic [6:0] e;
        string      t;
        @(posedge clk);
        #1;
        mem_read = mr; ex_rd = rd; rs1 = s1; rs2 = s2;
        use1 = u1; use2 = u2; ex_mc = mc; done = dn; br = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #4;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, {9'd0, pc_wr, ifid_wr, idex_wr, ifid_fl, idex_fl, exmem_bub, mc_st}, {9'd0, e});
    endtask

    task automatic idle(input logic [6:0] exp, input string tag);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    initial begin
        rst = 1'b1;
        idle(C_DEF, "ctrl_in_reset");
        idle(C_DEF, "ctrl_in_reset2");
        rst = 1'b0;
        idle(C_DEF, "ctrl_after_reset");
        chk("lu_cnt_reset", 16'(lu_cnt), 16'd0);
        chk("mc_cnt_reset", 16'(mc_cnt), 16'd0);
        chk("tout_reset", 16'(tout), 16'd0);
        chk("state_reset", 16'(st), 16'd0);

        step(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, "lu_rs1");
        idle(C_DEF, "lu_one_cycle");
        chk("lu_cnt_1", 16'(lu_cnt), 16'd1);
        step(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, "lu_rd_zero");
        step(1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, "lu_rs2_unused");
        step(1'b1, 5'd5, 5'd7, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, "lu_rs2");
        step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_DEF, "no_memread");
        chk("lu_cnt_2", 16'(lu_cnt), 16'd2);

        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_BR, "br_over_lu");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_BR, "br_over_mc");
        idle(C_DEF, "after_branch");
        chk("lu_cnt_br", 16'(lu_cnt), 16'd2);
        chk("state_br", 16'(st), 16'd0);

        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCS, "mc_start");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY, "mc_busy1");
        chk("state_busy", 16'(st), 16'd1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_BUSY, "mc_busy_br");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY, "mc_busy3");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_DEF, "mc_done");
        chk("mc_cnt_3", 16'(mc_cnt), 16'd3);
        idle(C_DEF, "mc_back_run");
        chk("state_run", 16'(st), 16'd0);
        chk("tout_short_mc", 16'(tout), 16'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_DEF, "done_in_run");
        idle(C_DEF, "after_done_in_run");
        chk("state_done_run", 16'(st), 16'd0);

        for (int i = 0; i < 13; i++) begin
            step(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, "lu_fill");
        end
        idle(C_DEF, "lu_fill_end");
        chk("lu_cnt_max", 16'(lu_cnt), 16'd15);
        step(1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, "lu_sat");
        idle(C_DEF, "lu_sat_end");
        chk("lu_cnt_sat", 16'(lu_cnt), 16'd15);

        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCS, "to_start");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY, "to_busy");
        end
        chk("tout_before_max", 16'(tout), 16'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY, "to_busy5");
        chk("tout_set", 16'(tout), 16'd1);
        chk("state_wait", 16'(st), 16'd1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_DEF, "to_done");
        idle(C_DEF, "to_back_run");
        chk("state_after_to", 16'(st), 16'd0);
        chk("tout_sticky", 16'(tout), 16'd1);
        chk("mc_cnt_8", 16'(mc_cnt), 16'd8);

        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCS, "rst_mc_start");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BUSY, "rst_mc_busy");
        rst = 1'b1;
        idle(C_DEF, "ctrl_rst_mid_busy");
        rst = 1'b0;
        idle(C_DEF, "ctrl_after_rst_busy");
        chk("state_rst_busy", 16'(st), 16'd0);
        chk("tout_cleared", 16'(tout), 16'd0);
        chk("lu_cnt_cleared", 16'(lu_cnt), 16'd0);
        chk("mc_cnt_cleared", 16'(mc_cnt), 16'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MCS, "mc_start_again");

        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
